// File: rtl/mac_pkg.sv
// Shared defaults and feeder state encoding for the MAC operand path.
package mac_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFill  = 2'b01,
    StIssue = 2'b10,
    StRun   = 2'b11
  } feeder_state_e;

  // Occupancy counter needs one extra bit to represent "full".
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Upstream pair stream plus MAC-controller handshake, bundled for the feeder.
interface mac_operand_feeder_if
  import mac_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          go;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_last;
  logic          fetch;
  logic          done;
  logic          busy;
  logic          err;

  modport slave (
    input  in_valid, in_a, in_b, in_last, fetch, done,
    output in_ready, go, op_a, op_b, op_last, busy, err
  );

  modport master (
    output in_valid, in_a, in_b, in_last, fetch, done,
    input  in_ready, go, op_a, op_b, op_last, busy, err
  );

endinterface

// File: rtl/mac_pair_fifo.sv
// Operand-pair FIFO with synchronous flush; push when full and pop when empty are dropped.
module mac_pair_fifo
  import mac_pkg::*;
#(
  parameter int unsigned W     = 2 * DW_DEF + 1,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [W-1:0]            i_wdata,
  output logic [W-1:0]            o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [cnt_w(DEPTH)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Collects an operand vector, pulses go to the MAC controller, then feeds pairs on each fetch.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input logic                  clk,
  input logic                  rst,
  mac_operand_feeder_if.slave  bus
);

  localparam int unsigned PW = 2 * DW + 1;
  localparam int unsigned CW = cnt_w(DEPTH);

  feeder_state_e r_state;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [PW-1:0] w_head;
  logic          w_in_phase;
  logic          w_accept;
  logic          w_run;
  logic          w_pop;
  logic          w_flush;
  logic          w_fetch_bad;
  logic          w_overflow;

  assign w_in_phase  = (r_state == StIdle) || (r_state == StFill);
  assign w_run       = (r_state == StRun) && !rst;
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_pop       = w_run && bus.fetch && !w_empty;
  assign w_fetch_bad = bus.fetch && !((r_state == StRun) && !w_empty);
  // The beat that would fill the buffer without closing the vector.
  assign w_overflow  = w_accept && !bus.in_last && (w_count == CW'(DEPTH - 1));
  // A full buffer in IDLE can only be the aftermath of an overflow.
  assign w_flush     = ((r_state == StRun) && bus.done) || ((r_state == StIdle) && w_full);

  mac_pair_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({bus.in_a, bus.in_b, bus.in_last}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_err   <= 1'b0;
    end else begin
      if (w_fetch_bad || w_overflow) r_err <= 1'b1;
      unique case (r_state)
        StIdle, StFill: begin
          if (w_accept) begin
            if (bus.in_last)     r_state <= StIssue;
            else if (w_overflow) r_state <= StIdle;
            else                 r_state <= StFill;
          end
        end
        StIssue: r_state <= StRun;
        StRun:   if (bus.done) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = !rst && w_in_phase && !w_full;
  assign bus.go       = !rst && (r_state == StIssue);
  assign bus.busy     = w_run;
  assign bus.err      = r_err;

  always_comb begin
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.op_last = 1'b0;
    if (w_run && !w_empty) begin
      {bus.op_a, bus.op_b, bus.op_last} = w_head;
    end
  end

endmodule
